// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Brings up the on-chip PLL and gates the downstream system reset.
// 1. Hold the PLL in reset for a fixed time.
// 2. Wait for extlock.
// 3. Require lock to stay high for a qualification window.
// 4. Release sys_rst_n.
//
// Lock that does not arrive in time triggers a bounded number of retries
// before the block parks in FAULT. Lock lost while running restarts the
// sequence and is counted.
//
// All logic runs on refclk, the same reference that feeds the PLL, so the
// sequencer keeps working while the PLL output is absent or unstable.
//
// Parameters
//   RST_HOLD_CYC      refclk cycles pll_reset is held per attempt
//   LOCK_STABLE_CYC   consecutive locked cycles required before release
//   LOCK_TIMEOUT_CYC  cycles allowed in WAIT_LOCK before a retry
//   MAX_RETRY         retries after the first attempt (1..3)
//   CNT_W             shared counter width, 2^CNT_W >= every cycle parameter
//
// Ports
//   refclk         in   reference clock
//   reset_n        in   asynchronous active-low reset
//   pll_extlock    in   PLL lock indicator, asynchronous to refclk
//   sw_relock      in   synchronous restart request, level sampled
//   pll_reset      out  active-high PLL reset
//   sys_rst_n      out  active-low system reset (high only in RUN)
//   locked         out  high only in RUN
//   fault          out  high only in FAULT
//   retry_cnt      out  retries consumed in the current bring-up
//   lock_loss_cnt  out  saturating count of lock losses seen in RUN
//   state_dbg      out  0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYC     = 24,
    parameter int LOCK_STABLE_CYC  = 2400,
    parameter int LOCK_TIMEOUT_CYC = 240000,
    parameter int MAX_RETRY        = 3,
    parameter int CNT_W            = 18
) (
    input  logic       refclk,
    input  logic       reset_n,
    input  logic       pll_extlock,
    input  logic       sw_relock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Terminal counts: the counter starts at 0 on state entry, so the last
    // cycle of an N-cycle interval is N-1.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [1:0]        retry_cnt_reg;
    logic [1:0]        retry_cnt_next;
    logic [7:0]        lock_loss_cnt_reg;
    logic [7:0]        lock_loss_cnt_next;
    logic              sync1_reg;
    logic              lock_s_reg;
    logic              pll_reset_reg;
    logic              sys_rst_n_reg;
    logic              locked_reg;
    logic              fault_reg;

    // Two-flop synchroniser for the asynchronous lock indicator.
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg  <= 1'b0;
            lock_s_reg <= 1'b0;
        end else begin
            sync1_reg  <= pll_extlock;
            lock_s_reg <= sync1_reg;
        end
    end

    // Next-state logic. sw_relock overrides every state.
    always_comb begin
        state_next         = state_reg;
        retry_cnt_next     = retry_cnt_reg;
        lock_loss_cnt_next = lock_loss_cnt_reg;

        if (sw_relock) begin
            state_next     = ST_RESET_PLL;
            retry_cnt_next = 2'd0;
        end else begin
            case (state_reg)
                ST_RESET_PLL: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is checked first so it wins on the timeout cycle.
                    if (lock_s_reg) begin
                        state_next = ST_STABLE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        if (retry_cnt_reg < RETRY_LIMIT) begin
                            retry_cnt_next = retry_cnt_reg + 2'd1;
                            state_next     = ST_RESET_PLL;
                        end else begin
                            state_next = ST_FAULT;
                        end
                    end
                end
                ST_STABLE: begin
                    // A drop returns to WAIT_LOCK. The timeout window
                    // restarts, but the retry budget is not refunded.
                    if (!lock_s_reg) begin
                        state_next = ST_WAIT_LOCK;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next     = ST_RUN;
                        retry_cnt_next = 2'd0;
                    end
                end
                ST_RUN: begin
                    if (!lock_s_reg) begin
                        state_next = ST_RESET_PLL;
                        if (lock_loss_cnt_reg != 8'hFF) begin
                            lock_loss_cnt_next = lock_loss_cnt_reg + 8'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_RESET_PLL;
                end
            endcase
        end

        // The counter restarts on every state entry. A held sw_relock keeps
        // it pinned at 0, which stretches the PLL reset for as long as the
        // request is held.
        if (sw_relock || (state_next != state_reg)) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // State, counters, and output flops. The outputs decode state_next, so
    // they are correct on the first cycle of each state.
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= ST_RESET_PLL;
            cnt_reg           <= '0;
            retry_cnt_reg     <= 2'd0;
            lock_loss_cnt_reg <= 8'd0;
            pll_reset_reg     <= 1'b1;
            sys_rst_n_reg     <= 1'b0;
            locked_reg        <= 1'b0;
            fault_reg         <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            retry_cnt_reg     <= retry_cnt_next;
            lock_loss_cnt_reg <= lock_loss_cnt_next;
            pll_reset_reg     <= (state_next == ST_RESET_PLL) || (state_next == ST_FAULT);
            sys_rst_n_reg     <= (state_next == ST_RUN);
            locked_reg        <= (state_next == ST_RUN);
            fault_reg         <= (state_next == ST_FAULT);
        end
    end

    assign pll_reset     = pll_reset_reg;
    assign sys_rst_n     = sys_rst_n_reg;
    assign locked        = locked_reg;
    assign fault         = fault_reg;
    assign retry_cnt     = retry_cnt_reg;
    assign lock_loss_cnt = lock_loss_cnt_reg;
    assign state_dbg     = state_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Scoreboard bench for pll_lock_sequencer.
//
// Stimulus code pushes timed expectations (cycle, output, value) into a
// queue. A monitor runs on the falling edge, pops every entry due for the
// current cycle, and compares it against the DUT. Cycle 0 is the cycle just
// after reset_n is released; cycle k follows the k-th rising edge after it.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    localparam int SEL_STATE = 0;
    localparam int SEL_PLL   = 1;
    localparam int SEL_SYS   = 2;
    localparam int SEL_LOCK  = 3;
    localparam int SEL_FAULT = 4;
    localparam int SEL_RETRY = 5;
    localparam int SEL_LLC   = 6;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    logic       refclk;
    logic       reset_n;
    logic       pll_extlock;
    logic       sw_relock;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state_dbg;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc;
    exp_t sb[$];

    pll_lock_sequencer #(
        .RST_HOLD_CYC     (4),
        .LOCK_STABLE_CYC  (8),
        .LOCK_TIMEOUT_CYC (32),
        .MAX_RETRY        (2),
        .CNT_W            (18)
    ) dut (
        .refclk        (refclk),
        .reset_n       (reset_n),
        .pll_extlock   (pll_extlock),
        .sw_relock     (sw_relock),
        .pll_reset     (pll_reset),
        .sys_rst_n     (sys_rst_n),
        .locked        (locked),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt),
        .state_dbg     (state_dbg)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Cycle counter, restarted by reset so expectations are relative to release.
    always @(posedge refclk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    function automatic logic [31:0] get_obs(input int sel);
        case (sel)
            SEL_STATE: return 32'(state_dbg);
            SEL_PLL:   return 32'(pll_reset);
            SEL_SYS:   return 32'(sys_rst_n);
            SEL_LOCK:  return 32'(locked);
            SEL_FAULT: return 32'(fault);
            SEL_RETRY: return 32'(retry_cnt);
            SEL_LLC:   return 32'(lock_loss_cnt);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Insert an expectation, keeping the queue ordered by cycle.
    function automatic void push_exp(input int c, input int sel, input logic [31:0] v, input string tag);
        exp_t e;
        int   i;
        e.cyc = c;
        e.sel = sel;
        e.val = v;
        e.tag = tag;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge refclk) begin
        if (reset_n) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                check_val($sformatf("%s@%0d", e.tag, e.cyc), get_obs(e.sel), e.val);
            end
        end
    end

    // Advance to just after rising edge k (reset_n must be high).
    task automatic goto_cyc(input int k);
        while (cyc < k) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge refclk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_state"}, 32'(state_dbg), 0);
        check_val({tag, "_pll"},   32'(pll_reset), 1);
        check_val({tag, "_sys"},   32'(sys_rst_n), 0);
        check_val({tag, "_lock"},  32'(locked), 0);
        check_val({tag, "_fault"}, 32'(fault), 0);
        check_val({tag, "_retry"}, 32'(retry_cnt), 0);
        check_val({tag, "_llc"},   32'(lock_loss_cnt), 0);
    endtask

    initial begin
        int t;
        reset_n     = 1'b0;
        pll_extlock = 1'b0;
        sw_relock   = 1'b0;
        apply_reset();

        // Clean bring-up: reset values, 4-cycle PLL reset, lock at cycle 20.
        push_exp(0, SEL_STATE, 0, "rst_state");
        push_exp(0, SEL_PLL, 1, "rst_pll");
        push_exp(0, SEL_SYS, 0, "rst_sys");
        push_exp(0, SEL_LOCK, 0, "rst_lock");
        push_exp(0, SEL_FAULT, 0, "rst_fault");
        push_exp(0, SEL_RETRY, 0, "rst_retry");
        push_exp(0, SEL_LLC, 0, "rst_llc");
        push_exp(3, SEL_PLL, 1, "hold_pll");
        push_exp(4, SEL_PLL, 0, "rel_pll");
        push_exp(4, SEL_STATE, 1, "wait_state");
        goto_cyc(20);
        pll_extlock = 1'b1;
        push_exp(22, SEL_STATE, 1, "sync_state");
        push_exp(23, SEL_STATE, 2, "stable_state");
        push_exp(30, SEL_STATE, 2, "stable_end");
        push_exp(30, SEL_SYS, 0, "stable_sys");
        push_exp(31, SEL_STATE, 3, "run_state");
        push_exp(31, SEL_SYS, 1, "run_sys");
        push_exp(31, SEL_LOCK, 1, "run_lock");
        push_exp(31, SEL_RETRY, 0, "run_retry");
        push_exp(31, SEL_PLL, 0, "run_pll");

        // Lock loss in RUN.
        goto_cyc(40);
        pll_extlock = 1'b0;
        push_exp(42, SEL_STATE, 3, "loss_pre");
        push_exp(42, SEL_LOCK, 1, "loss_pre_lock");
        push_exp(43, SEL_SYS, 0, "loss_sys");
        push_exp(43, SEL_LOCK, 0, "loss_lock");
        push_exp(43, SEL_PLL, 1, "loss_pll");
        push_exp(43, SEL_LLC, 1, "loss_llc");
        push_exp(43, SEL_STATE, 0, "loss_state");
        push_exp(46, SEL_PLL, 1, "loss_pll_end");
        push_exp(47, SEL_PLL, 0, "loss_pll_rel");
        push_exp(47, SEL_STATE, 1, "loss_wait");

        // Stability glitch: one-cycle drop while in STABLE.
        goto_cyc(50);
        pll_extlock = 1'b1;
        push_exp(53, SEL_STATE, 2, "gl_stable");
        goto_cyc(56);
        pll_extlock = 1'b0;
        goto_cyc(57);
        pll_extlock = 1'b1;
        push_exp(58, SEL_STATE, 2, "gl_pre");
        push_exp(59, SEL_STATE, 1, "gl_wait");
        push_exp(59, SEL_SYS, 0, "gl_sys");
        push_exp(60, SEL_STATE, 2, "gl_restable");
        push_exp(67, SEL_STATE, 2, "gl_full8");
        push_exp(67, SEL_SYS, 0, "gl_full8_sys");
        push_exp(68, SEL_STATE, 3, "gl_run");
        push_exp(68, SEL_SYS, 1, "gl_run_sys");
        push_exp(68, SEL_RETRY, 0, "gl_retry");

        // sw_relock in RUN, single cycle.
        goto_cyc(75);
        sw_relock = 1'b1;
        push_exp(75, SEL_STATE, 3, "sw_pre");
        push_exp(76, SEL_STATE, 0, "sw_state");
        push_exp(76, SEL_PLL, 1, "sw_pll");
        push_exp(76, SEL_SYS, 0, "sw_sys");
        push_exp(76, SEL_LLC, 1, "sw_llc");
        goto_cyc(76);
        sw_relock = 1'b0;
        push_exp(79, SEL_PLL, 1, "sw_pll_end");
        push_exp(80, SEL_PLL, 0, "sw_pll_rel");
        push_exp(80, SEL_STATE, 1, "sw_wait");
        push_exp(81, SEL_STATE, 2, "sw_stable");
        push_exp(89, SEL_STATE, 3, "sw_run");

        // sw_relock held: 10 cycles pinned after entry, then the normal 4.
        goto_cyc(95);
        sw_relock = 1'b1;
        push_exp(96, SEL_STATE, 0, "swh_state");
        push_exp(96, SEL_PLL, 1, "swh_pll0");
        push_exp(105, SEL_PLL, 1, "swh_pll9");
        push_exp(109, SEL_PLL, 1, "swh_pll13");
        push_exp(109, SEL_STATE, 0, "swh_state13");
        push_exp(110, SEL_PLL, 0, "swh_pll_rel");
        push_exp(110, SEL_STATE, 1, "swh_wait");
        push_exp(111, SEL_STATE, 2, "swh_stable");
        push_exp(119, SEL_STATE, 3, "swh_run");
        push_exp(119, SEL_LLC, 1, "swh_llc");
        goto_cyc(106);
        sw_relock = 1'b0;

        // No lock: three 32-cycle WAIT_LOCK periods, then FAULT.
        goto_cyc(125);
        pll_extlock = 1'b0;
        push_exp(127, SEL_STATE, 3, "nl_pre");
        push_exp(128, SEL_STATE, 0, "nl_reset");
        push_exp(128, SEL_LLC, 2, "nl_llc");
        push_exp(132, SEL_STATE, 1, "nl_wait0");
        push_exp(163, SEL_STATE, 1, "nl_wait0_end");
        push_exp(163, SEL_RETRY, 0, "nl_retry0");
        push_exp(164, SEL_STATE, 0, "nl_retry1_state");
        push_exp(164, SEL_RETRY, 1, "nl_retry1");
        push_exp(168, SEL_STATE, 1, "nl_wait1");
        push_exp(199, SEL_STATE, 1, "nl_wait1_end");
        push_exp(200, SEL_STATE, 0, "nl_retry2_state");
        push_exp(200, SEL_RETRY, 2, "nl_retry2");
        push_exp(204, SEL_STATE, 1, "nl_wait2");
        push_exp(235, SEL_STATE, 1, "nl_wait2_end");
        push_exp(236, SEL_STATE, 4, "nl_fault_state");
        push_exp(236, SEL_FAULT, 1, "nl_fault");
        push_exp(236, SEL_PLL, 1, "nl_fault_pll");
        push_exp(236, SEL_RETRY, 2, "nl_fault_retry");
        push_exp(236, SEL_SYS, 0, "nl_fault_sys");
        push_exp(249, SEL_STATE, 4, "nl_fault_hold");

        // Leave FAULT with a single-cycle sw_relock.
        goto_cyc(250);
        sw_relock = 1'b1;
        push_exp(250, SEL_STATE, 4, "fr_pre");
        push_exp(251, SEL_STATE, 0, "fr_state");
        push_exp(251, SEL_FAULT, 0, "fr_fault");
        push_exp(251, SEL_RETRY, 0, "fr_retry");
        push_exp(251, SEL_PLL, 1, "fr_pll");
        push_exp(251, SEL_LLC, 2, "fr_llc");
        goto_cyc(251);
        sw_relock = 1'b0;
        goto_cyc(255);
        pll_extlock = 1'b1;
        push_exp(255, SEL_STATE, 1, "fr_wait");
        push_exp(257, SEL_STATE, 1, "fr_wait_sync");
        push_exp(258, SEL_STATE, 2, "fr_stable");
        push_exp(266, SEL_STATE, 3, "fr_run");
        push_exp(266, SEL_SYS, 1, "fr_run_sys");

        // Asynchronous reset mid-RUN, asserted between clock edges.
        goto_cyc(270);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("arst_run");
        repeat (3) @(posedge refclk);
        #1;
        reset_n = 1'b1;
        push_exp(0, SEL_STATE, 0, "r2_state");
        push_exp(0, SEL_PLL, 1, "r2_pll");
        push_exp(0, SEL_LLC, 0, "r2_llc");
        push_exp(4, SEL_STATE, 1, "r2_wait");
        push_exp(5, SEL_STATE, 2, "r2_stable");
        push_exp(8, SEL_STATE, 2, "r2_stable_mid");

        // Asynchronous reset mid-STABLE, after the cycle-8 sample.
        goto_cyc(8);
        #5;
        reset_n = 1'b0;
        #1;
        check_reset_vals("arst_stable");
        repeat (3) @(posedge refclk);
        #1;
        reset_n = 1'b1;
        push_exp(0, SEL_STATE, 0, "r3_state");
        push_exp(3, SEL_PLL, 1, "r3_pll");
        push_exp(4, SEL_PLL, 0, "r3_pll_rel");
        push_exp(4, SEL_STATE, 1, "r3_wait");
        push_exp(5, SEL_STATE, 2, "r3_stable");
        push_exp(12, SEL_STATE, 2, "r3_stable_end");
        push_exp(12, SEL_SYS, 0, "r3_sys0");
        push_exp(13, SEL_STATE, 3, "r3_run");
        push_exp(13, SEL_SYS, 1, "r3_sys1");
        push_exp(13, SEL_LOCK, 1, "r3_lock");
        push_exp(13, SEL_LLC, 0, "r3_llc");

        // 257 lock losses: lock_loss_cnt saturates at 255.
        for (int k = 1; k <= 257; k++) begin
            t = 20 * k;
            goto_cyc(t);
            pll_extlock = 1'b0;
            push_exp(t + 3, SEL_LLC, (k > 255) ? 255 : k, "sat_llc");
            push_exp(t + 3, SEL_STATE, 0, "sat_reset");
            goto_cyc(t + 3);
            pll_extlock = 1'b1;
            push_exp(t + 16, SEL_STATE, 3, "sat_run");
        end
        goto_cyc(20 * 258 + 2);

        check_val("pending", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
